// File: rtl/arith_unit_mdu_pkg.sv
// Shared opcode and state definitions for the iterative multiply/divide arithmetic unit.
package arith_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_SUB = 3'd1;
  localparam op_t OP_AND = 3'd2;
  localparam op_t OP_NOT = 3'd3;
  localparam op_t OP_SHL = 3'd4;
  localparam op_t OP_SHR = 3'd5;
  localparam op_t OP_MUL = 3'd6;
  localparam op_t OP_DIV = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/arith_unit_mdu_if.sv
// Control-unit handshake bus: start/op/operands in, busy/done/results out.
interface arith_unit_mdu_if
  import arith_unit_pkg::*;
#(
  parameter int W  = 30,
  parameter int SW = 5
);
  logic          start_from_ac;
  op_t           op_from_ac;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [SW-1:0] shift_amt;
  logic          busy_to_ac;
  logic          done_to_ac;
  logic [W-1:0]  result_lo;
  logic [W-1:0]  result_hi;
  logic          carry_out_to_ac;
  logic          div_by_zero_to_ac;

  modport master (
    output start_from_ac, op_from_ac, operand_a, operand_b, shift_amt,
    input  busy_to_ac, done_to_ac, result_lo, result_hi, carry_out_to_ac, div_by_zero_to_ac
  );

  modport slave (
    input  start_from_ac, op_from_ac, operand_a, operand_b, shift_amt,
    output busy_to_ac, done_to_ac, result_lo, result_hi, carry_out_to_ac, div_by_zero_to_ac
  );
endinterface

// File: rtl/arith_unit_mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit, subtract the divisor if it fits.
module arith_unit_divstep #(
  parameter int W = 30
) (
  input  logic [W-1:0] rem,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);
  logic [W:0] trial;

  // rem < divisor always holds, so {rem,bit} - divisor fits in W+1 bits signed
  assign trial    = {rem, dividend_bit} - {1'b0, divisor};
  assign q_bit    = ~trial[W];
  assign rem_next = q_bit ? trial[W-1:0] : {rem[W-2:0], dividend_bit};
endmodule

// File: rtl/arith_unit_mdu.sv
// Iterative arithmetic unit: add/sub/logic in one cycle, shifts/multiply/divide one step per clock.
// Optional macro ARITH_UNIT_MUL_ZERO_SKIP_EN ends MUL early once the remaining multiplier bits are zero.
module arith_unit_mdu
  import arith_unit_pkg::*;
#(
  parameter int W  = 30,
  parameter int SW = 5
) (
  input  logic clk,
  input  logic reset,
  arith_unit_mdu_if.slave bus
);
  localparam int CW = SW + 1;
  localparam logic [CW-1:0] CNT_W   = CW'(W);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  state_t         state;
  op_t            op_q;
  logic [W-1:0]   divisor_q;
  logic [W-1:0]   work;
  logic [W-1:0]   rem;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] mcand;
  logic [CW-1:0]  cnt;

  logic [W:0]     add_sum;
  logic [W:0]     sub_sum;
  logic [W-1:0]   sh_next;
  logic           sh_out;
  logic [2*W-1:0] acc_next;
  logic [W-1:0]   rem_next;
  logic [W-1:0]   quo_next;
  logic           q_bit;
  logic           mul_last;
  logic           mul_trivial;

  assign add_sum = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
  assign sub_sum = {1'b0, bus.operand_a} + {1'b0, ~bus.operand_b} + {{W{1'b0}}, 1'b1};

  always_comb begin
    sh_next = work >> 1;
    sh_out  = work[0];
    if (op_q == OP_SHL) begin
      sh_next = work << 1;
      sh_out  = work[W-1];
    end
  end

  assign acc_next = work[0] ? acc + mcand : acc;

`ifdef ARITH_UNIT_MUL_ZERO_SKIP_EN
  assign mul_last    = (cnt == CNT_ONE) || (work[W-1:1] == '0);
  assign mul_trivial = (bus.operand_a == '0) || (bus.operand_b == '0);
`else
  assign mul_last    = (cnt == CNT_ONE);
  assign mul_trivial = 1'b0;
`endif

  arith_unit_divstep #(.W(W)) u_divstep (
    .rem          (rem),
    .dividend_bit (work[W-1]),
    .divisor      (divisor_q),
    .rem_next     (rem_next),
    .q_bit        (q_bit)
  );

  // quotient bits shift in from the right as dividend bits leave on the left
  assign quo_next = {work[W-2:0], q_bit};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                 <= ST_IDLE;
      op_q                  <= OP_ADD;
      divisor_q             <= '0;
      work                  <= '0;
      rem                   <= '0;
      acc                   <= '0;
      mcand                 <= '0;
      cnt                   <= '0;
      bus.busy_to_ac        <= 1'b0;
      bus.done_to_ac        <= 1'b0;
      bus.result_lo         <= '0;
      bus.result_hi         <= '0;
      bus.carry_out_to_ac   <= 1'b0;
      bus.div_by_zero_to_ac <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          bus.done_to_ac <= 1'b0;
          if (bus.start_from_ac) begin
            op_q                  <= bus.op_from_ac;
            divisor_q             <= bus.operand_b;
            rem                   <= '0;
            bus.busy_to_ac        <= 1'b1;
            bus.carry_out_to_ac   <= 1'b0;
            bus.div_by_zero_to_ac <= 1'b0;
            state                 <= ST_DONE;
            bus.done_to_ac        <= 1'b1;
            case (bus.op_from_ac)
              OP_ADD: begin
                bus.result_lo       <= add_sum[W-1:0];
                bus.result_hi       <= '0;
                bus.carry_out_to_ac <= add_sum[W];
              end
              OP_SUB: begin
                bus.result_lo       <= sub_sum[W-1:0];
                bus.result_hi       <= '0;
                bus.carry_out_to_ac <= sub_sum[W];
              end
              OP_AND: begin
                bus.result_lo <= bus.operand_a & bus.operand_b;
                bus.result_hi <= '0;
              end
              OP_NOT: begin
                bus.result_lo <= ~bus.operand_a;
                bus.result_hi <= '0;
              end
              OP_SHL, OP_SHR: begin
                if (bus.shift_amt == '0) begin
                  bus.result_lo <= bus.operand_a;
                  bus.result_hi <= '0;
                end else begin
                  work           <= bus.operand_a;
                  cnt            <= {1'b0, bus.shift_amt};
                  state          <= ST_RUN;
                  bus.done_to_ac <= 1'b0;
                end
              end
              OP_MUL: begin
                if (mul_trivial) begin
                  bus.result_lo <= '0;
                  bus.result_hi <= '0;
                end else begin
                  acc            <= '0;
                  mcand          <= {{W{1'b0}}, bus.operand_a};
                  work           <= bus.operand_b;
                  cnt            <= CNT_W;
                  state          <= ST_RUN;
                  bus.done_to_ac <= 1'b0;
                end
              end
              OP_DIV: begin
                if (bus.operand_b == '0) begin
                  bus.result_lo         <= '1;
                  bus.result_hi         <= bus.operand_a;
                  bus.div_by_zero_to_ac <= 1'b1;
                end else begin
                  work           <= bus.operand_a;
                  cnt            <= CNT_W;
                  state          <= ST_RUN;
                  bus.done_to_ac <= 1'b0;
                end
              end
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_ONE;
          case (op_q)
            OP_SHL, OP_SHR: begin
              work <= sh_next;
              if (cnt == CNT_ONE) begin
                bus.result_lo       <= sh_next;
                bus.result_hi       <= '0;
                bus.carry_out_to_ac <= sh_out;
                state               <= ST_DONE;
                bus.done_to_ac      <= 1'b1;
              end
            end
            OP_MUL: begin
              acc   <= acc_next;
              mcand <= mcand << 1;
              work  <= work >> 1;
              if (mul_last) begin
                bus.result_lo  <= acc_next[W-1:0];
                bus.result_hi  <= acc_next[2*W-1:W];
                state          <= ST_DONE;
                bus.done_to_ac <= 1'b1;
              end
            end
            OP_DIV: begin
              rem  <= rem_next;
              work <= quo_next;
              if (cnt == CNT_ONE) begin
                bus.result_lo  <= quo_next;
                bus.result_hi  <= rem_next;
                state          <= ST_DONE;
                bus.done_to_ac <= 1'b1;
              end
            end
            default: begin
              state          <= ST_DONE;
              bus.done_to_ac <= 1'b1;
            end
          endcase
        end
        ST_DONE: begin
          state          <= ST_IDLE;
          bus.busy_to_ac <= 1'b0;
          bus.done_to_ac <= 1'b0;
        end
        default: begin
          state          <= ST_IDLE;
          bus.busy_to_ac <= 1'b0;
          bus.done_to_ac <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_arith_unit_mdu.sv
// Self-checking bench: latency-countdown reference model compared every cycle, plus directed literal cases.
module tb_arith_unit_mdu;
  localparam int W  = 30;
  localparam int SW = 5;
  localparam longint unsigned M = (64'd1 << W) - 64'd1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  bit   chk_en;

  arith_unit_mdu_if #(.W(W), .SW(SW)) bus ();

  arith_unit_mdu #(.W(W), .SW(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int msb_idx(input longint unsigned v);
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic bit skip_en();
`ifdef ARITH_UNIT_MUL_ZERO_SKIP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Spec-level result and latency of one operation
  task automatic model_op(input logic [2:0] op, input longint unsigned a, input longint unsigned b,
                          input int n, output longint unsigned lo, output longint unsigned hi,
                          output bit c, output bit dbz, output int lat);
    longint unsigned s;
    lo = 0; hi = 0; c = 0; dbz = 0; lat = 1;
    case (op)
      3'd0: begin s = a + b; lo = s & M; c = s[W]; end
      3'd1: begin s = a + ((~b) & M) + 1; lo = s & M; c = s[W]; end
      3'd2: lo = a & b;
      3'd3: lo = (~a) & M;
      3'd4: begin
        s = a << n; lo = s & M; c = (n == 0) ? 1'b0 : s[W]; lat = n + 1;
      end
      3'd5: begin
        lo = a >> n; s = (n == 0) ? 64'd0 : (a >> (n - 1)); c = s[0]; lat = n + 1;
      end
      3'd6: begin
        s = a * b; lo = s & M; hi = s >> W;
        if (skip_en()) lat = (a == 0 || b == 0) ? 1 : msb_idx(b) + 2;
        else lat = W + 1;
      end
      default: begin
        if (b == 0) begin lo = M; hi = a; dbz = 1; lat = 1; end
        else begin lo = a / b; hi = a % b; lat = W + 1; end
      end
    endcase
  endtask

  longint unsigned m_lo, m_hi, p_lo, p_hi;
  bit m_busy, m_done, m_c, m_dbz, p_c, p_dbz;
  int m_rem, p_lat;

  initial begin
    m_lo = 0; m_hi = 0; m_busy = 0; m_done = 0; m_c = 0; m_dbz = 0; m_rem = 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lo = 0; m_hi = 0; m_busy = 0; m_done = 0; m_c = 0; m_dbz = 0; m_rem = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_lo = p_lo; m_hi = p_hi; m_c = p_c; m_dbz = p_dbz; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (bus.start_from_ac) begin
      model_op(bus.op_from_ac, 64'(bus.operand_a), 64'(bus.operand_b), int'(bus.shift_amt),
               p_lo, p_hi, p_c, p_dbz, p_lat);
      m_busy = 1; m_c = 0; m_dbz = 0;
      m_rem = p_lat - 1;
      if (m_rem == 0) begin
        m_lo = p_lo; m_hi = p_hi; m_c = p_c; m_dbz = p_dbz; m_done = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(bus.busy_to_ac), 64'(m_busy));
      chk("done", 64'(bus.done_to_ac), 64'(m_done));
      chk("result_lo", 64'(bus.result_lo), m_lo);
      chk("result_hi", 64'(bus.result_hi), m_hi);
      chk("carry", 64'(bus.carry_out_to_ac), 64'(m_c));
      chk("div_by_zero", 64'(bus.div_by_zero_to_ac), 64'(m_dbz));
    end
  end

  task automatic drive(input bit st, input logic [2:0] op, input longint unsigned a,
                       input longint unsigned b, input int n);
    bus.start_from_ac = st;
    bus.op_from_ac    = op;
    bus.operand_a     = a[W-1:0];
    bus.operand_b     = b[W-1:0];
    bus.shift_amt     = SW'(n);
  endtask

  // Issue one op from IDLE; lat is the cycle count from the accepting edge to done (0 on timeout)
  task automatic run_op(input logic [2:0] op, input longint unsigned a, input longint unsigned b,
                        input int n, input int pulse_at, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (bus.busy_to_ac && g < 200) begin
      @(negedge clk);
      g++;
    end
    drive(1'b1, op, a, b, n);
    lat = 0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (bus.done_to_ac) begin
        lat = k;
        break;
      end
      if (k == pulse_at) drive(1'b1, 3'd0, 64'd777, 64'd888, 3);
      else drive(1'b0, op, a, b, n);
    end
    drive(1'b0, op, a, b, n);
  endtask

  function automatic longint unsigned rnd_val();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return M;
      2: return 64'($urandom_range(0, 15));
      default: return 64'($urandom) & M;
    endcase
  endfunction

  int lat;

  initial begin
    checks = 0; errors = 0; chk_en = 0;
    reset = 1'b1;
    drive(1'b0, 3'd0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", 64'(bus.busy_to_ac), 0);
    chk("reset_done", 64'(bus.done_to_ac), 0);
    chk("reset_lo", 64'(bus.result_lo), 0);
    chk("reset_hi", 64'(bus.result_hi), 0);
    chk("reset_carry", 64'(bus.carry_out_to_ac), 0);
    chk("reset_dbz", 64'(bus.div_by_zero_to_ac), 0);
    chk_en = 1;

    run_op(3'd0, 64'h3FFFFFFF, 64'd1, 0, 0, lat);
    chk("add_lat", lat, 1); chk("add_lo", 64'(bus.result_lo), 0);
    chk("add_carry", 64'(bus.carry_out_to_ac), 1); chk("add_hi", 64'(bus.result_hi), 0);

    run_op(3'd1, 64'd5, 64'd7, 0, 0, lat);
    chk("sub_lo", 64'(bus.result_lo), 64'h3FFFFFFE); chk("sub_carry", 64'(bus.carry_out_to_ac), 0);

    run_op(3'd6, 64'h3FFFFFFF, 64'h3FFFFFFF, 0, 0, lat);
    chk("mul_max_lat", lat, 31);
    chk("mul_max_hi", 64'(bus.result_hi), 64'h3FFFFFFE); chk("mul_max_lo", 64'(bus.result_lo), 1);

    run_op(3'd6, 64'd12345, 64'd4, 0, 0, lat);
    chk("mul_b4_lat", lat, skip_en() ? 4 : 31);
    chk("mul_b4_lo", 64'(bus.result_lo), 64'd49380); chk("mul_b4_hi", 64'(bus.result_hi), 0);

    run_op(3'd7, 64'd1000, 64'd7, 0, 0, lat);
    chk("div_lat", lat, 31); chk("div_lo", 64'(bus.result_lo), 142); chk("div_hi", 64'(bus.result_hi), 6);

    run_op(3'd7, 64'd9, 64'd0, 0, 0, lat);
    chk("div0_lat", lat, 1); chk("div0_lo", 64'(bus.result_lo), 64'h3FFFFFFF);
    chk("div0_hi", 64'(bus.result_hi), 9); chk("div0_flag", 64'(bus.div_by_zero_to_ac), 1);

    run_op(3'd4, 64'h20000001, 64'd0, 1, 0, lat);
    chk("shl1_lat", lat, 2); chk("shl1_lo", 64'(bus.result_lo), 2);
    chk("shl1_carry", 64'(bus.carry_out_to_ac), 1);

    run_op(3'd5, 64'h1234567, 64'd0, 0, 0, lat);
    chk("shr0_lat", lat, 1); chk("shr0_lo", 64'(bus.result_lo), 64'h1234567);

    run_op(3'd5, 64'h3FFFFFFF, 64'd0, 31, 0, lat);
    chk("shr31_lat", lat, 32); chk("shr31_lo", 64'(bus.result_lo), 0);
    chk("shr31_carry", 64'(bus.carry_out_to_ac), 0);

    run_op(3'd6, 64'd1000, 64'd3000, 0, 5, lat);
    chk("mul_ign_lat", lat, skip_en() ? 13 : 31);
    chk("mul_ign_lo", 64'(bus.result_lo), 64'd3000000); chk("mul_ign_hi", 64'(bus.result_hi), 0);

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    drive(1'b1, 3'd7, 64'd123456, 64'd11, 0);
    @(negedge clk);
    drive(1'b0, 3'd0, 0, 0, 0);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy_to_ac), 0);
    chk("arst_lo", 64'(bus.result_lo), 0);
    chk("arst_hi", 64'(bus.result_hi), 0);
    chk("arst_done", 64'(bus.done_to_ac), 0);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    run_op(3'd0, 64'd5, 64'd6, 0, 0, lat);
    chk("post_rst_add_lat", lat, 1); chk("post_rst_add_lo", 64'(bus.result_lo), 11);

    // random traffic, including starts while busy
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), rnd_val(), rnd_val(),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 3)));
    end
    drive(1'b0, 3'd0, 0, 0, 0);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
